// File: rtl/diff_wrap_operator_multi_if.sv
// Frame bus for the difference/wrap stage.
// The master drives the start pulse and the folded input frame.
// The slave returns the raw differences, the wrapped residuals and the busy/done status.
interface diff_wrap_operator_multi_if #(
  parameter int ROWS = 8,
  parameter int W    = 16,
  parameter int DW   = 18
);
  logic                 en;
  logic signed [W-1:0]  in       [ROWS];
  logic signed [DW-1:0] diff_out [ROWS];
  logic signed [DW-1:0] out      [ROWS];
  logic                 busy;
  logic                 done;

  modport master (
    output en, in,
    input  diff_out, out, busy, done
  );

  modport slave (
    input  en, in,
    output diff_out, out, busy, done
  );
endinterface

// File: rtl/diff_wrap_operator_multi.sv
// ORDER-th finite difference of a folded sample frame, computed with one
// subtract per cycle. The history carries across frames, so back-to-back
// frames behave as one continuous stream. Every difference is folded into
// [-2^(WRAP_BITS-1), 2^(WRAP_BITS-1)-1] and sign-extended for the
// antidifference stage.
module diff_wrap_operator_multi #(
  parameter int ROWS      = 8,
  parameter int ORDER     = 2,
  parameter int W         = 16,
  parameter int DW        = W + ORDER,
  parameter int WRAP_BITS = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  diff_wrap_operator_multi_if.slave  bus
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = $clog2(ORDER + 1);

  localparam logic [RW-1:0] R_LAST  = RW'(ROWS - 1);
  localparam logic [RW-1:0] R_ZERO  = RW'(0);
  localparam logic [RW-1:0] R_ONE   = RW'(1);
  localparam logic [KW-1:0] K_FIRST = KW'(1);
  localparam logic [KW-1:0] K_LAST  = KW'(ORDER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WRAP = 2'd2
  } state_t;

  state_t               state_r;
  logic [KW-1:0]        k_r;                  // current difference order, 1..ORDER
  logic [RW-1:0]        r_r;                  // current row, walks down from ROWS-1
  logic signed [DW-1:0] wk_r   [ROWS];        // in-place difference array
  logic signed [DW-1:0] hist_r [1:ORDER];     // last order k-1 value of previous frame
  logic signed [DW-1:0] pend_r [1:ORDER];     // history of this frame, committed at WRAP
  logic signed [DW-1:0] sub_s;
  logic signed [DW-1:0] diff_s;

  // Widen a signed input sample to the difference width.
  function automatic logic signed [DW-1:0] sext_in(input logic signed [W-1:0] v);
    sext_in = DW'(v);
  endfunction

  // Two's-complement fold: keep the low WRAP_BITS bits, then sign-extend them.
  function automatic logic signed [DW-1:0] fold_wrap(input logic signed [DW-1:0] v);
    logic signed [WRAP_BITS-1:0] low;
    low       = v[WRAP_BITS-1:0];
    fold_wrap = DW'(low);
  endfunction

  // Subtrahend: row 0 uses the history of the previous frame; every other row
  // uses its lower neighbour, which still holds order k-1 because rows descend.
  always_comb begin
    sub_s = hist_r[k_r];
    if (r_r != R_ZERO) begin
      sub_s = wk_r[r_r - R_ONE];
    end else begin
      sub_s = hist_r[k_r];
    end
    diff_s = wk_r[r_r] - sub_s;
  end

  // Frame sequencer: load, descend through rows for each order, then fold and publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      k_r      <= K_FIRST;
      r_r      <= R_LAST;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        wk_r[i]         <= {DW{1'b0}};
        bus.diff_out[i] <= {DW{1'b0}};
        bus.out[i]      <= {DW{1'b0}};
      end
      for (int j = 1; j <= ORDER; j++) begin
        hist_r[j] <= {DW{1'b0}};
        pend_r[j] <= {DW{1'b0}};
      end
    end else begin
      bus.done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.en) begin
            for (int i = 0; i < ROWS; i++) begin
              wk_r[i] <= sext_in(bus.in[i]);
            end
            k_r      <= K_FIRST;
            r_r      <= R_LAST;
            bus.busy <= 1'b1;
            state_r  <= ST_RUN;
          end
        end
        ST_RUN: begin
          wk_r[r_r] <= diff_s;
          // The top row still holds the last order k-1 value on its first visit.
          if (r_r == R_LAST) begin
            pend_r[k_r] <= wk_r[R_LAST];
          end
          if (r_r == R_ZERO) begin
            if (k_r == K_LAST) begin
              state_r <= ST_WRAP;
            end else begin
              k_r <= k_r + K_FIRST;
              r_r <= R_LAST;
            end
          end else begin
            r_r <= r_r - R_ONE;
          end
        end
        ST_WRAP: begin
          for (int i = 0; i < ROWS; i++) begin
            bus.diff_out[i] <= wk_r[i];
            bus.out[i]      <= fold_wrap(wk_r[i]);
          end
          for (int j = 1; j <= ORDER; j++) begin
            hist_r[j] <= pend_r[j];
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/diff_wrap_operator_multi.md
Name: diff_wrap_operator_multi

Overview:
- Upstream stage of the antidifference operator in the unlimited-sampling recovery chain.
- Takes a frame of ROWS folded (modulo) samples and computes the ORDER-th finite difference sequentially, one subtract per cycle.
- Difference history carries across frames, so consecutive frames behave as one continuous stream.
- Folds each difference into the centred range [-2^(WRAP_BITS-1), 2^(WRAP_BITS-1)-1] and presents the residual vector with a done pulse, ready for the antidifference stage.

Parameters:
- ROWS, 8: samples per frame (>=2).
- ORDER, 2: difference order (>=1).
- W, 16: signed input sample width.
- DW, W+ORDER: width of raw difference and wrapped outputs.
- WRAP_BITS, 12: fold modulus is 2^WRAP_BITS, i.e. 2*lambda with lambda = 2^(WRAP_BITS-1); requires WRAP_BITS <= DW.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- en  in  1  start pulse; frame accepted when idle.
- in  in  ROWS x W  signed frame, row 0 oldest.
- diff_out  out  ROWS x DW  signed raw ORDER-th differences of the last frame.
- out  out  ROWS x DW  signed wrapped residuals (sign-extended).
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; outputs valid from this cycle on.

Behaviour:
- Reset (clk sampled with reset=1):
  - State goes to IDLE.
  - Work array wk[ROWS], history hist[1..ORDER], pending history, diff_out, out: all cleared to 0.
  - busy=0, done=0.
  - Reset overrides everything, including mid-frame.
  - The first frame after reset uses hist=0.
- IDLE:
  - If en=1, sign-extend in[] into wk[] (DW bits).
  - Clear the order counter k to 1 and set the row counter r to ROWS-1.
  - Go to RUN. busy=1 from the next cycle.
- RUN: one row per cycle, rows descending so wk[r-1] still holds order k-1.
  - wk[r] <= wk[r] - (r==0 ? hist[k] : wk[r-1]), with DW-bit arithmetic.
  - At r==ROWS-1, also capture pend[k] <= old wk[ROWS-1], the last order k-1 value.
  - At r==0: if k==ORDER go to WRAP; otherwise k<=k+1 and r<=ROWS-1.
  - RUN lasts exactly ORDER*ROWS cycles.
- WRAP (1 cycle):
  - diff_out[i] <= wk[i].
  - out[i] <= sign-extension of wk[i][WRAP_BITS-1:0] to DW bits.
  - hist[k] <= pend[k] for all k; done <= 1; busy <= 0; go to IDLE.
- Latency: en sampled at edge E, done high after edge E+ORDER*ROWS+1, for exactly one cycle.
- diff_out and out hold their values until the next WRAP or reset.
- en while busy (RUN/WRAP) is ignored: no queuing, in[] is not sampled.
- en in the cycle done is high is accepted (state is IDLE), which gives back-to-back frames with period ORDER*ROWS+2.
- in[] only needs to be stable in the cycle en is accepted.
- No saturation: DW = W+ORDER is guaranteed sufficient for differences. The fold is a pure two's-complement truncation plus sign extension.
- Reset during RUN discards the frame: no done, history stays 0, pend is not committed.

Test Plan:
All scenarios use ROWS=4, ORDER=2, W=8, DW=10, WRAP_BITS=4.
1. After reset, en with in={1,2,3,4}
   -> done exactly 9 cycles after en
   -> diff_out={1,0,0,0}, out={1,0,0,0}
   -> busy high for 9 cycles.
2. Immediately after scenario 1, en in the done cycle with in={5,6,7,8}
   -> accepted (history order1=4, order2=1)
   -> diff_out={0,0,0,0}, out={0,0,0,0}
   -> done 9 cycles later.
3. After reset, in={0,10,20,30}
   -> diff_out={0,10,0,0}, out={0,-6,0,0}.
4. After reset, in={-100,0,0,0}
   -> diff_out={-100,200,-100,0}, out={-4,-8,-4,0}.
5. Scenario 1 stimulus, then a second en with in={9,9,9,9} three cycles later
   -> ignored; exactly one done pulse; results as scenario 1.
6. Scenario 1 stimulus, then reset asserted 4 cycles after en
   -> no done; busy=0 and all outputs 0 the cycle after reset.
   -> A following en with {1,2,3,4} reproduces scenario 1 exactly (history cleared).
